masked_state_serializer: RTL
============================

MASKED_STATE_SERIALIZER -- requirements
Module: masked_state_serializer

Interface
REQ-001 SHALL have parameter SHARES, default 2, number of Boolean shares (masking order d+1).
REQ-002 SHALL have parameter BYTES, default 16, bytes per share (AES state width).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port load  input  1  request to capture sh_in.
REQ-006 SHALL have port sh_in  input  8*BYTES*SHARES  share s on bits [8*BYTES*s +: 8*BYTES].
REQ-007 SHALL have port out_ready  input  1  downstream accepts the current byte.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid byte group.
REQ-009 SHALL have port out_data  output  8*SHARES  one byte per share; lane s on bits [8*s +: 8].
REQ-010 SHALL have port out_last  output  1  current byte group is the final one.
REQ-011 SHALL have port busy  output  1  serialization in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the final transfer.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and SEND.
REQ-014 SHALL, in IDLE with load=1, capture every share into its own BYTES-byte shift register, clear the byte counter, and enter SEND on the next edge.
REQ-015 SHALL ignore load while in SEND; the registers and counter are unaffected.
REQ-016 SHALL assert out_valid and busy exactly while in SEND, so the first valid byte group appears one cycle after load is accepted.
REQ-017 SHALL drive each out_data lane s from the most significant byte of share register s; byte BYTES-1 goes out first and byte 0 last.
REQ-018 SHALL keep share lanes in separate registers with no logic combining two shares, so no share-recombining path exists.
REQ-019 SHALL, on out_valid&out_ready, shift every share register left by 8 bits, fill zeros into the low byte, and increment the counter.
REQ-020 SHALL hold out_data, out_valid and the counter stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-021 SHALL assert out_last iff in SEND and counter = BYTES-1.
REQ-022 SHALL, on a handshake with out_last=1, return to IDLE and assert done for exactly the following cycle.
REQ-023 SHALL accept a load asserted in the same cycle as done, and restart serialization with no bubble beyond REQ-016.
REQ-024 SHALL keep the counter width at ceil(log2(BYTES)) bits with no wrap past BYTES-1; BYTES=1 makes the first group also the last.
REQ-025 SHALL leave all share registers zero after a complete serialization, so no share material stays resident.
REQ-026 SHALL drive out_data to zero whenever out_valid=0.

Reset
REQ-027 SHALL, with rst_n=0 at a rising edge, enter IDLE and clear the share registers, the counter, out_valid, out_last, busy and done to 0, regardless of the current state.
REQ-028 SHALL let reset take priority over load and over a handshake in the same cycle.
REQ-029 SHALL treat a reset during SEND as an abort: no done pulse, and the registers are zeroed.

Verification
REQ-030 SHALL cover: SHARES=2, share0=000102...0F, share1=share0 XOR 69c4e0d86a7b0430d8cdb78070b4c55a, load pulse, out_ready=1 -> 16 consecutive groups; the first group is lane0=0F and lane1=0F^5a=55; the last group is lane0=00 and lane1=69 with out_last=1; done is high the following cycle.
REQ-031 SHALL cover: same stimulus with out_ready toggling 1,0,0,1,... -> lane values identical to the previous scenario, each group held through stall cycles, exactly 16 handshakes.
REQ-032 SHALL cover: load pulsed again at byte 5 during SEND -> output stream unchanged from the first scenario.
REQ-033 SHALL cover: rst_n=0 for one cycle after 7 handshakes -> next cycle out_valid=0, busy=0, done=0, and all registers zero.
REQ-034 SHALL cover: a new load asserted in the done cycle with share0=FF..FF -> the next cycle out_valid=1 and lane0=FF.
REQ-035 SHALL cover: BYTES=1, SHARES=3 -> one group with out_last=1 on its first cycle, followed by a done pulse.

Source files
------------

// File: rtl/masked_state_serializer.sv
// -----------------------------------------------------------------------------
// masked_state_serializer
//
// Serializes a Boolean-masked state (SHARES shares of BYTES bytes each) one
// byte group per handshake. Every share lives in its own shift register, and
// nothing ever combines two shares, so no path holds the unmasked value.
// Byte BYTES-1 of every share goes out first and byte 0 goes out last. Each
// shift fills zeros behind the outgoing byte, so a completed (or reset)
// serialization leaves no share material resident.
//
// Parameters
//   SHARES : number of Boolean shares (masking order + 1)
//   BYTES  : bytes per share
//
// Ports
//   clk        : clock, every state update happens on the rising edge
//   rst_n      : synchronous active-low reset; it aborts any transfer
//   load       : capture sh_in (honoured only while idle)
//   sh_in      : share s on bits [8*BYTES*s +: 8*BYTES]
//   out_ready  : downstream accepts the current byte group
//   out_valid  : out_data holds a valid byte group
//   out_data   : one byte per share, lane s on bits [8*s +: 8]; zero when idle
//   out_last   : current group is the final one
//   busy       : serialization in progress
//   done       : one-cycle pulse after the final transfer
// -----------------------------------------------------------------------------
module masked_state_serializer #(
   parameter int SHARES = 2,
   parameter int BYTES  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic [8*BYTES*SHARES-1:0] sh_in,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic [8*SHARES-1:0]       out_data,
   output logic                      out_last,
   output logic                      busy,
   output logic                      done
);

   localparam int SW = 8 * BYTES;
   // A single-byte state still needs a one-bit counter to exist; it never
   // leaves zero in that case.
   localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(BYTES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          capture;
   logic          shift;

   assign out_valid = (state_q == SEND);
   assign busy      = (state_q == SEND);
   assign out_last  = (state_q == SEND) && (cnt_q == LAST_CNT);
   assign done      = done_q;

   // Control: load is only looked at in IDLE, so a load during SEND is
   // simply never seen. A load in the done cycle is an ordinary IDLE load.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      capture = 1'b0;
      shift   = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               capture = 1'b1;
               cnt_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (out_ready) begin
               shift = 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // One independent register per share; the lane output reads only its own
   // share, so shares never meet in any logic cone.
   for (genvar s = 0; s < SHARES; s++) begin : g_share
      logic [SW-1:0] sh_q, sh_d;

      always_comb begin
         sh_d = sh_q;
         if (capture) begin
            sh_d = sh_in[SW*s +: SW];
         end else if (shift) begin
            sh_d = sh_q << 8;
         end
      end

      // The share registers are cleared on reset as well, so an aborted
      // transfer leaves nothing resident.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            sh_q <= '0;
         end else begin
            sh_q <= sh_d;
         end
      end

      assign out_data[8*s +: 8] = (state_q == SEND) ? sh_q[SW-1 -: 8] : 8'h00;
   end

endmodule
